// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared writeback-control constants, used both by the WB decode ROM and by
// the writeback executor (wb_reg_writer / wb_sel_mux).
//   WADD_* : address-select encodings carried in WB_CNT[4:2]
//   WDAT_* : data-select encodings carried in WB_CNT[1]
//   state_t: writeback executor FSM states
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [2:0] WADD_RD   = 3'b000;
    localparam logic [2:0] WADD_RN   = 3'b001;
    localparam logic [2:0] WADD_LR   = 3'b010;
    localparam logic [2:0] WADD_DUAL = 3'b011;

    localparam logic WDAT_ALU = 1'b0;
    localparam logic WDAT_MEM = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

endpackage : wb_pkg

// File: rtl/wb_sel_mux.sv
// -----------------------------------------------------------------------------
// wb_sel_mux
// Combinational decode of the 5-bit writeback control word into the first
// register-file write of a request.
// Ports:
//   cnt    in   5   [4:2] address select, [1] data select, [0] write enable
//   rd     in   AW  destination index
//   rn     in   AW  base index
//   alu    in   DW  ALU result / updated base address
//   mem    in   DW  memory load data
//   we     out  1   request produces a write
//   err    out  1   reserved address select with write enable set
//   dual   out  1   load-with-base-writeback (second write to rn follows)
//   waddr  out  AW  first write index
//   wdata  out  DW  first write data
// -----------------------------------------------------------------------------
module wb_sel_mux
    import wb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int LR_IDX = 14
) (
    input  logic [4:0]    cnt,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rn,
    input  logic [DW-1:0] alu,
    input  logic [DW-1:0] mem,
    output logic          we,
    output logic          err,
    output logic          dual,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);

    logic [2:0] wadd_sel;
    logic       wdat_sel;
    logic       w_bit;

    assign wadd_sel = cnt[4:2];
    assign wdat_sel = cnt[1];
    assign w_bit    = cnt[0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        we    = 1'b0;
        err   = 1'b0;
        dual  = 1'b0;
        waddr = rd;
        wdata = (wdat_sel == WDAT_MEM) ? mem : alu;

        unique case (wadd_sel)
            WADD_RD: begin
                we    = w_bit;
                waddr = rd;
            end
            WADD_RN: begin
                we    = w_bit;
                waddr = rn;
            end
            WADD_LR: begin
                we    = w_bit;
                waddr = AW'(LR_IDX);
            end
            WADD_DUAL: begin
                // First half of load-with-writeback always writes the load data,
                // the data-select bit is meaningless here.
                we    = w_bit;
                dual  = w_bit;
                waddr = rd;
                wdata = mem;
            end
            default: begin
                // Reserved selects never write; flag them only when a write was asked for.
                err = w_bit;
            end
        endcase
    end

endmodule : wb_sel_mux

// File: rtl/wb_reg_writer.sv
// -----------------------------------------------------------------------------
// wb_reg_writer
// Writeback-stage executor. Converts accepted writeback control words into
// registered register-file write pulses, including the two-cycle
// load-with-base-writeback (DUAL) sequence, flags R15 writes for fetch
// redirect, and keeps a forwarding entry of the last register written.
// Ports:
//   clk        in   1   clock
//   reset_n    in   1   asynchronous active-low reset
//   wb_valid   in   1   writeback request valid
//   wb_ready   out  1   request accepted on wb_valid & wb_ready at a rising edge
//   wb_cnt     in   5   writeback control word
//   wb_rd      in   AW  destination index
//   wb_rn      in   AW  base index
//   wb_alu     in   DW  ALU result / updated base address
//   wb_mem     in   DW  memory load data
//   rf_we      out  1   register-file write strobe (one pulse per write)
//   rf_waddr   out  AW  register-file write index (holds when rf_we=0)
//   rf_wdata   out  DW  register-file write data  (holds when rf_we=0)
//   pc_we      out  1   R15 written this cycle
//   pc_wdata   out  DW  redirect target, valid with pc_we
//   fwd_valid  out  1   forwarding entry valid
//   fwd_addr   out  AW  last register written
//   fwd_data   out  DW  last data written
//   wb_err     out  1   reserved select with write enable
// -----------------------------------------------------------------------------
module wb_reg_writer
    import wb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int LR_IDX = 14,
    parameter int PC_IDX = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [4:0]    wb_cnt,
    input  logic [AW-1:0] wb_rd,
    input  logic [AW-1:0] wb_rn,
    input  logic [DW-1:0] wb_alu,
    input  logic [DW-1:0] wb_mem,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          pc_we,
    output logic [DW-1:0] pc_wdata,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data,
    output logic          wb_err
);

    state_t        state_q, state_d;
    logic          ready_q;

    // Pending second half of a DUAL request
    logic [AW-1:0] second_addr_q;
    logic [DW-1:0] second_data_q;
    logic          second_en_q;
    logic          load_second;

    // Decoded first write of the incoming request
    logic          sel_we, sel_err, sel_dual;
    logic [AW-1:0] sel_waddr;
    logic [DW-1:0] sel_wdata;

    // Write to be registered at the next edge
    logic          w_en, w_err;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    logic          accept;

    wb_sel_mux #(
        .DW     (DW),
        .AW     (AW),
        .LR_IDX (LR_IDX)
    ) u_sel_mux (
        .cnt   (wb_cnt),
        .rd    (wb_rd),
        .rn    (wb_rn),
        .alu   (wb_alu),
        .mem   (wb_mem),
        .we    (sel_we),
        .err   (sel_err),
        .dual  (sel_dual),
        .waddr (sel_waddr),
        .wdata (sel_wdata)
    );

    // ready_q keeps wb_ready low throughout reset and rises at the first edge after release.
    assign wb_ready = ready_q && (state_q == IDLE);
    assign accept   = wb_valid && wb_ready;

    always_comb begin
        state_d     = state_q;
        w_en        = 1'b0;
        w_err       = 1'b0;
        w_addr      = sel_waddr;
        w_data      = sel_wdata;
        load_second = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    w_en  = sel_we;
                    w_err = sel_err;
                    if (sel_dual) begin
                        load_second = 1'b1;
                        state_d     = SECOND;
                    end
                end
            end
            SECOND: begin
                // Occupies the cycle even when Rd==Rn suppressed the write.
                w_en    = second_en_q;
                w_addr  = second_addr_q;
                w_data  = second_data_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every flop here is reset, including the pending-write latch, so a DUAL cut by reset cannot leak a write.
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            second_addr_q <= '0;
            second_data_q <= '0;
            second_en_q   <= 1'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            pc_we         <= 1'b0;
            pc_wdata      <= '0;
            fwd_valid     <= 1'b0;
            fwd_addr      <= '0;
            fwd_data      <= '0;
            wb_err        <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            rf_we   <= w_en;
            wb_err  <= w_err;
            pc_we   <= w_en && (w_addr == AW'(PC_IDX));

            if (load_second) begin
                second_addr_q <= wb_rn;
                second_data_q <= wb_alu;
                // Load data wins when base and destination coincide.
                second_en_q   <= (wb_rn != wb_rd);
            end

            if (w_en) begin
                rf_waddr  <= w_addr;
                rf_wdata  <= w_data;
                fwd_valid <= 1'b1;
                fwd_addr  <= w_addr;
                fwd_data  <= w_data;
                if (w_addr == AW'(PC_IDX)) begin
                    pc_wdata <= w_data;
                end
            end
        end
    end

endmodule : wb_reg_writer

// File: tb/tb_wb_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_wb_reg_writer
// Self-checking bench for wb_reg_writer. The reference model is a queue of
// per-cycle expected write slots: each accepted request appends the writes it
// must produce, one slot per output cycle, and the executor is ready only when
// no slot is outstanding.
// -----------------------------------------------------------------------------
module tb_wb_reg_writer;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wb_valid;
    logic          wb_ready;
    logic [4:0]    wb_cnt;
    logic [AW-1:0] wb_rd;
    logic [AW-1:0] wb_rn;
    logic [DW-1:0] wb_alu;
    logic [DW-1:0] wb_mem;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pc_we;
    logic [DW-1:0] pc_wdata;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
    logic          wb_err;

    always #5 clk = ~clk;

    wb_reg_writer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_cnt    (wb_cnt),
        .wb_rd     (wb_rd),
        .wb_rn     (wb_rn),
        .wb_alu    (wb_alu),
        .wb_mem    (wb_mem),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pc_we     (pc_we),
        .pc_wdata  (pc_wdata),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .wb_err    (wb_err)
    );

    typedef struct {
        bit          we;
        bit          err;
        logic [3:0]  addr;
        logic [31:0] data;
    } slot_t;

    slot_t       sched[$];
    bit          out_of_reset;
    bit          m_fwd_valid;
    logic [3:0]  m_last_addr;
    logic [31:0] m_last_data;
    logic [31:0] m_last_pc;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        out_of_reset = 1'b0;
        m_fwd_valid  = 1'b0;
        m_last_addr  = '0;
        m_last_data  = '0;
        m_last_pc    = '0;
    endtask

    // Writes an accepted request must produce, straight from the control-word rules.
    task automatic model_accept(input logic [4:0] c, input logic [3:0] rd_i, input logic [3:0] rn_i,
                                input logic [31:0] alu_i, input logic [31:0] mem_i);
        int    sel;
        slot_t s;
        sel = int'(c[4:2]);
        s   = '{we: 1'b0, err: 1'b0, addr: 4'd0, data: 32'd0};
        if (c[0] == 1'b0) begin
            sched.push_back(s);
        end else if (sel >= 4) begin
            s.err = 1'b1;
            sched.push_back(s);
        end else if (sel == 3) begin
            sched.push_back('{we: 1'b1, err: 1'b0, addr: rd_i, data: mem_i});
            if (rn_i != rd_i) sched.push_back('{we: 1'b1, err: 1'b0, addr: rn_i, data: alu_i});
            else              sched.push_back(s);
        end else begin
            s.we   = 1'b1;
            s.addr = (sel == 0) ? rd_i : (sel == 1) ? rn_i : 4'd14;
            s.data = c[1] ? mem_i : alu_i;
            sched.push_back(s);
        end
    endtask

    // Called just after a rising edge: consume one expected slot and compare.
    task automatic compare_outputs(input string tag);
        slot_t s;
        bit    exp_pc;
        if (sched.size() > 0) s = sched.pop_front();
        else                  s = '{we: 1'b0, err: 1'b0, addr: 4'd0, data: 32'd0};
        exp_pc = s.we && (s.addr == 4'd15);
        if (s.we) begin
            m_fwd_valid = 1'b1;
            m_last_addr = s.addr;
            m_last_data = s.data;
            if (exp_pc) m_last_pc = s.data;
        end
        check({tag, ".rf_we"},     32'(rf_we),     32'(s.we));
        check({tag, ".rf_waddr"},  32'(rf_waddr),  32'(m_last_addr));
        check({tag, ".rf_wdata"},  rf_wdata,       m_last_data);
        check({tag, ".pc_we"},     32'(pc_we),     32'(exp_pc));
        check({tag, ".pc_wdata"},  pc_wdata,       m_last_pc);
        check({tag, ".wb_err"},    32'(wb_err),    32'(s.err));
        check({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(m_fwd_valid));
        check({tag, ".fwd_addr"},  32'(fwd_addr),  32'(m_last_addr));
        check({tag, ".fwd_data"},  fwd_data,       m_last_data);
    endtask

    // One clock cycle: drive, check readiness, model acceptance, compare results.
    task automatic step(input string tag, input logic v, input logic [4:0] c,
                        input logic [3:0] rd_i, input logic [3:0] rn_i,
                        input logic [31:0] alu_i, input logic [31:0] mem_i);
        bit exp_ready;
        wb_valid = v;
        wb_cnt   = c;
        wb_rd    = rd_i;
        wb_rn    = rn_i;
        wb_alu   = alu_i;
        wb_mem   = mem_i;
        @(negedge clk);
        exp_ready = out_of_reset && (sched.size() == 0);
        check({tag, ".wb_ready"}, 32'(wb_ready), 32'(exp_ready));
        if (v && exp_ready) model_accept(c, rd_i, rn_i, alu_i, mem_i);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rf_we"},     32'(rf_we),     32'd0);
        check({tag, ".pc_we"},     32'(pc_we),     32'd0);
        check({tag, ".wb_err"},    32'(wb_err),    32'd0);
        check({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
        check({tag, ".wb_ready"},  32'(wb_ready),  32'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        out_of_reset = 1'b1;
        check({tag, ".ready_after_release"}, 32'(wb_ready), 32'd1);
    endtask

    logic [4:0] cnt_pool [12] = '{5'b00001, 5'b00011, 5'b00101, 5'b00111, 5'b01001, 5'b01011,
                                  5'b01101, 5'b01111, 5'b10001, 5'b11011, 5'b00000, 5'b01100};

    initial begin
        logic [3:0] r_rd, r_rn;
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        wb_cnt   = '0;
        wb_rd    = '0;
        wb_rn    = '0;
        wb_alu   = '0;
        wb_mem   = '0;
        model_reset();

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset("reset");

        // Single write
        step("single", 1'b1, 5'b00001, 4'd3, 4'd0, 32'h1234, 32'h0);
        idle_step("single_idle");

        // Load with base writeback
        step("dual_1", 1'b1, 5'b01101, 4'd2, 4'd5, 32'h1004, 32'hAA);
        step("dual_2", 1'b1, 5'b00001, 4'd7, 4'd7, 32'hDEAD, 32'hBEEF);
        idle_step("dual_3");

        // DUAL with Rd==Rn, back-to-back request held off one cycle
        step("dual_eq_1", 1'b1, 5'b01101, 4'd4, 4'd4, 32'h2000, 32'h55);
        step("dual_eq_2", 1'b1, 5'b00101, 4'd1, 4'd9, 32'h99, 32'h0);
        step("dual_eq_3", 1'b1, 5'b00101, 4'd1, 4'd9, 32'h99, 32'h0);

        // PC write, single pulse
        step("pc_wr", 1'b1, 5'b00011, 4'd15, 4'd0, 32'h0, 32'h8000);
        idle_step("pc_idle");

        // LR select and PC as DUAL base
        step("lr_wr", 1'b1, 5'b01001, 4'd0, 4'd0, 32'h1414, 32'h0);
        step("dual_pc_1", 1'b1, 5'b01111, 4'd15, 4'd6, 32'h600, 32'h15F);
        step("dual_pc_2", 1'b0, 5'b0, 4'd0, 4'd0, 32'h0, 32'h0);

        // Reserved and no-write control words
        step("reserved", 1'b1, 5'b10001, 4'd3, 4'd3, 32'h1, 32'h2);
        step("reserved_nw", 1'b1, 5'b11000, 4'd3, 4'd3, 32'h1, 32'h2);
        step("no_write", 1'b1, 5'b00000, 4'd8, 4'd8, 32'h3, 32'h4);
        idle_step("after_nw");

        // Reset during SECOND discards the pending base write
        step("rst_dual_1", 1'b1, 5'b01101, 4'd10, 4'd11, 32'hB0B0, 32'hA0A0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        release_reset("rst_mid");
        for (int i = 0; i < 3; i++) idle_step("rst_after");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_rd = 4'($urandom);
            r_rn = ($urandom_range(0, 3) == 0) ? r_rd : 4'($urandom);
            if ($urandom_range(0, 7) == 0) r_rd = 4'd15;
            step("rand", $urandom_range(0, 3) != 0, cnt_pool[$urandom_range(0, 11)],
                 r_rd, r_rn, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wb_reg_writer
